// File: rtl/t06_head_tracker.sv
// Snake head tracker: moves the head one cell per step, checks against live borders, flags wall hits.
// Optional T06_HEAD_WRAP_EN: moves past a border wrap to the opposite border instead of killing the snake.
module t06_head_tracker #(
    parameter logic [3:0] X_INIT   = 4'd4,
    parameter logic [3:0] Y_INIT   = 4'd3,
    parameter logic [1:0] DIR_INIT = 2'b11
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       enable_in,
    input  logic       step,
    input  logic [1:0] dir_in,
    input  logic [3:0] XMAX,
    input  logic [3:0] XMIN,
    input  logic [3:0] YMAX,
    input  logic [3:0] YMIN,
    output logic [3:0] head_x,
    output logic [3:0] head_y,
    output logic [1:0] heading,
    output logic       moved,
    output logic       wall_hit,
    output logic [1:0] state
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DEAD = 2'b10;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    logic [3:0] head_x_q, head_x_d;
    logic [3:0] head_y_q, head_y_d;
    logic [1:0] heading_q, heading_d;
    logic       moved_q, moved_d;
    logic       wall_hit_q, wall_hit_d;
    logic [1:0] state_q, state_d;

    logic [1:0] eff_dir;
    logic [4:0] cand_x, cand_y;
    logic       head_in, cand_in;

    // Opposite headings share the high bit and differ only in the low bit.
    assign eff_dir = (dir_in == {heading_q[1], ~heading_q[0]}) ? heading_q : dir_in;

    // An inverted border pair (MIN > MAX) makes both checks false everywhere.
    assign head_in = (head_x_q >= XMIN) && (head_x_q <= XMAX) &&
                     (head_y_q >= YMIN) && (head_y_q <= YMAX);

    always_comb begin
        cand_x = {1'b0, head_x_q};
        cand_y = {1'b0, head_y_q};
        case (eff_dir)
            DIR_UP:    cand_y = {1'b0, head_y_q} - 5'd1;
            DIR_DOWN:  cand_y = {1'b0, head_y_q} + 5'd1;
            DIR_LEFT:  cand_x = {1'b0, head_x_q} - 5'd1;
            default:   cand_x = {1'b0, head_x_q} + 5'd1;
        endcase
`ifdef T06_HEAD_WRAP_EN
        // Wrap direction depends on travel: bit 4 means underflow when decrementing.
        case (eff_dir)
            DIR_UP:    if (cand_y[4] || cand_y < {1'b0, YMIN}) cand_y = {1'b0, YMAX};
            DIR_DOWN:  if (cand_y > {1'b0, YMAX}) cand_y = {1'b0, YMIN};
            DIR_LEFT:  if (cand_x[4] || cand_x < {1'b0, XMIN}) cand_x = {1'b0, XMAX};
            default:   if (cand_x > {1'b0, XMAX}) cand_x = {1'b0, XMIN};
        endcase
`endif
    end

    assign cand_in = (cand_x >= {1'b0, XMIN}) && (cand_x <= {1'b0, XMAX}) &&
                     (cand_y >= {1'b0, YMIN}) && (cand_y <= {1'b0, YMAX});

    always_comb begin
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        heading_d  = heading_q;
        moved_d    = 1'b0;
        wall_hit_d = wall_hit_q;
        state_d    = state_q;
        if (!enable_in) begin
            head_x_d   = X_INIT;
            head_y_d   = Y_INIT;
            heading_d  = DIR_INIT;
            wall_hit_d = 1'b0;
            state_d    = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN: begin
                    if (!head_in) begin
                        wall_hit_d = 1'b1;
                        state_d    = ST_DEAD;
                    end else if (step) begin
                        heading_d = eff_dir;
                        if (cand_in) begin
                            head_x_d = cand_x[3:0];
                            head_y_d = cand_y[3:0];
                            moved_d  = 1'b1;
                        end else begin
                            wall_hit_d = 1'b1;
                            state_d    = ST_DEAD;
                        end
                    end
                end
                default: state_d = ST_DEAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            head_x_q   <= X_INIT;
            head_y_q   <= Y_INIT;
            heading_q  <= DIR_INIT;
            moved_q    <= 1'b0;
            wall_hit_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            heading_q  <= heading_d;
            moved_q    <= moved_d;
            wall_hit_q <= wall_hit_d;
            state_q    <= state_d;
        end
    end

    assign head_x   = head_x_q;
    assign head_y   = head_y_q;
    assign heading  = heading_q;
    assign moved    = moved_q;
    assign wall_hit = wall_hit_q;
    assign state    = state_q;

endmodule

// File: tb/tb_t06_head_tracker.sv
// Directed bench for t06_head_tracker; expectations follow T06_HEAD_WRAP_EN when defined.
module tb_t06_head_tracker;

    logic       clk = 1'b0;
    logic       nrst;
    logic       enable_in;
    logic       step;
    logic [1:0] dir_in;
    logic [3:0] XMAX, XMIN, YMAX, YMIN;
    logic [3:0] head_x, head_y;
    logic [1:0] heading;
    logic       moved, wall_hit;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    t06_head_tracker dut (
        .clk(clk), .nrst(nrst), .enable_in(enable_in), .step(step), .dir_in(dir_in),
        .XMAX(XMAX), .XMIN(XMIN), .YMAX(YMAX), .YMIN(YMIN),
        .head_x(head_x), .head_y(head_y), .heading(heading),
        .moved(moved), .wall_hit(wall_hit), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Inputs change 1 time unit after the edge, outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] x, input logic [3:0] y,
                           input logic [1:0] h, input logic mv, input logic wh, input logic [1:0] st);
        chk({tag, ".x"}, {4'd0, head_x}, {4'd0, x});
        chk({tag, ".y"}, {4'd0, head_y}, {4'd0, y});
        chk({tag, ".hd"}, {6'd0, heading}, {6'd0, h});
        chk({tag, ".mv"}, {7'd0, moved}, {7'd0, mv});
        chk({tag, ".wh"}, {7'd0, wall_hit}, {7'd0, wh});
        chk({tag, ".st"}, {6'd0, state}, {6'd0, st});
    endtask

    task automatic do_step(input logic [1:0] d);
        step = 1'b1; dir_in = d;
        tick();
        step = 1'b0;
    endtask

    task automatic restart();
        enable_in = 1'b0; tick();
        enable_in = 1'b1; tick();
    endtask

    initial begin
        int mv_cnt;
        nrst = 1'b0; enable_in = 1'b0; step = 1'b0; dir_in = 2'b11;
        XMAX = 4'd15; XMIN = 4'd0; YMAX = 4'd11; YMIN = 4'd0;
        tick(); tick();
        chk_all("reset", 4'd4, 4'd3, 2'b11, 1'b0, 1'b0, 2'b00);
        nrst = 1'b1;

        // Step in the entry cycle is ignored.
        enable_in = 1'b1; step = 1'b1; dir_in = 2'b11;
        tick();
        chk_all("entry", 4'd4, 4'd3, 2'b11, 1'b0, 1'b0, 2'b01);

        mv_cnt = 0;
        tick(); mv_cnt += int'(moved); chk_all("r1", 4'd5, 4'd3, 2'b11, 1'b1, 1'b0, 2'b01);
        tick(); mv_cnt += int'(moved); chk_all("r2", 4'd6, 4'd3, 2'b11, 1'b1, 1'b0, 2'b01);
        tick(); mv_cnt += int'(moved); chk_all("r3", 4'd7, 4'd3, 2'b11, 1'b1, 1'b0, 2'b01);
        step = 1'b0;
        tick(); mv_cnt += int'(moved); chk_all("idle_step", 4'd7, 4'd3, 2'b11, 1'b0, 1'b0, 2'b01);
        chk("mv_cnt", mv_cnt[7:0], 8'd3);

        // Disable has priority over a simultaneous step.
        enable_in = 1'b0; step = 1'b1; dir_in = 2'b00;
        tick();
        chk_all("disable", 4'd4, 4'd3, 2'b11, 1'b0, 1'b0, 2'b00);
        step = 1'b0; enable_in = 1'b1; tick();

        do_step(2'b10);
        chk_all("reverse", 4'd5, 4'd3, 2'b11, 1'b1, 1'b0, 2'b01);

        XMAX = 4'd8; YMAX = 4'd6;
        do_step(2'b11); do_step(2'b11); do_step(2'b11);
        chk_all("at8", 4'd8, 4'd3, 2'b11, 1'b1, 1'b0, 2'b01);
        do_step(2'b11);
`ifdef T06_HEAD_WRAP_EN
        chk_all("wrap_r", 4'd0, 4'd3, 2'b11, 1'b1, 1'b0, 2'b01);
        restart();
`else
        chk_all("wall", 4'd8, 4'd3, 2'b11, 1'b0, 1'b1, 2'b10);
        do_step(2'b00); do_step(2'b01);
        chk_all("dead", 4'd8, 4'd3, 2'b11, 1'b0, 1'b1, 2'b10);
        enable_in = 1'b0; tick();
        chk_all("dead_idle", 4'd4, 4'd3, 2'b11, 1'b0, 1'b0, 2'b00);
        enable_in = 1'b1; tick();
`endif

        // Walk to (0,3) heading down, then turn left into x underflow.
        do_step(2'b00);
        chk_all("up", 4'd4, 4'd2, 2'b00, 1'b1, 1'b0, 2'b01);
        for (int i = 0; i < 4; i++) do_step(2'b10);
        do_step(2'b01);
        chk_all("at0", 4'd0, 4'd3, 2'b01, 1'b1, 1'b0, 2'b01);
        do_step(2'b10);
`ifdef T06_HEAD_WRAP_EN
        chk_all("wrap_l", 4'd8, 4'd3, 2'b10, 1'b1, 1'b0, 2'b01);
`else
        chk_all("uflow", 4'd0, 4'd3, 2'b10, 1'b0, 1'b1, 2'b10);
`endif
        restart();

        // Border shrink with no step kills the snake in both builds.
        XMAX = 4'd15; YMAX = 4'd11;
        for (int i = 0; i < 6; i++) do_step(2'b11);
        chk_all("at10", 4'd10, 4'd3, 2'b11, 1'b1, 1'b0, 2'b01);
        XMAX = 4'd8;
        tick();
        chk_all("shrink", 4'd10, 4'd3, 2'b11, 1'b0, 1'b1, 2'b10);
        XMAX = 4'd15;
        restart();

        do_step(2'b01);
        chk_all("down", 4'd4, 4'd4, 2'b01, 1'b1, 1'b0, 2'b01);
        nrst = 1'b0; step = 1'b1; dir_in = 2'b10;
        tick();
        chk_all("mid_rst", 4'd4, 4'd3, 2'b11, 1'b0, 1'b0, 2'b00);
        nrst = 1'b1; step = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
